// File: rtl/pc_trace_chk_pkg.sv
// Shared types and constants for the commit-trace checker.
//
//   trace_chk_state_e : checker FSM states (IDLE, RUN, DONE, HANG)
//   HANG_LIMIT_DEFAULT: default idle-cycle budget before a hang is declared
//   trace_err_t       : first-error capture record {trace index, observed PC},
//                       sized for the widest supported configuration; the
//                       checker fills and reads only the low bits it needs.
package pc_trace_chk_pkg;

    localparam int HANG_LIMIT_DEFAULT = 256;

    localparam int TRACE_IDX_W_MAX = 32;
    localparam int TRACE_PC_W_MAX  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HANG = 2'd3
    } trace_chk_state_e;

    typedef struct packed {
        logic [TRACE_IDX_W_MAX-1:0] idx;
        logic [TRACE_PC_W_MAX-1:0]  pc;
    } trace_err_t;

endpackage

// File: rtl/pc_trace_mem.sv
// Golden-trace storage: DEPTH x PC_W, one synchronous write port and one
// asynchronous read port, no reset, so it maps onto distributed RAM.
//
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : expected PC to store
//   i_raddr : read index
//   o_rdata : stored PC at i_raddr (combinational)
module pc_trace_mem #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [PC_W-1:0]  i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [PC_W-1:0]  o_rdata
);

    logic [PC_W-1:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; a reset would prevent RAM inference
    // and the contents are defined by the load phase, not by reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pc_trace_checker.sv
// Commit-trace checker: compares each retired PC from the core against a
// preloaded golden trace and reports pass/fail, a saturating mismatch count,
// the first mismatch location and a hang (too many idle cycles in a run).
//
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_exp_we/addr/data: golden trace load port (honoured in IDLE only)
//   i_start, i_exp_len: start a run checking i_exp_len retirements
//   i_pc, i_insn_vld : core retired PC and its valid
//   o_busy           : run in progress
//   o_done           : run finished (DONE or HANG)
//   o_pass / o_fail  : finished clean / finished with errors or hung
//   o_hang           : run ended by the idle-cycle watchdog
//   o_err_cnt        : saturating mismatch count
//   o_ret_cnt        : retirements checked this run
//   o_first_err_idx/pc: trace index and observed PC of the first mismatch
module pc_trace_checker
    import pc_trace_chk_pkg::*;
#(
    parameter  int PC_W       = 32,
    parameter  int DEPTH      = 1024,
    parameter  int HANG_LIMIT = HANG_LIMIT_DEFAULT,
    parameter  int ERR_W      = 8,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_exp_we,
    input  logic [IDX_W-1:0] i_exp_addr,
    input  logic [PC_W-1:0]  i_exp_data,
    input  logic             i_start,
    input  logic [IDX_W:0]   i_exp_len,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_insn_vld,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_fail,
    output logic             o_hang,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [IDX_W:0]   o_ret_cnt,
    output logic [IDX_W-1:0] o_first_err_idx,
    output logic [PC_W-1:0]  o_first_err_pc
);

    localparam int              HC_W    = $clog2(HANG_LIMIT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    trace_chk_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q,  idx_d;
    logic [IDX_W:0]   len_q,  len_d;
    logic [IDX_W:0]   ret_q,  ret_d;
    logic [HC_W-1:0]  hang_q, hang_d;
    logic [ERR_W-1:0] err_q,  err_d;
    trace_err_t       cap_q,  cap_d;

    logic busy_q, done_q, pass_q, fail_q, hang_flag_q;
    logic busy_d, done_d, pass_d, fail_d, hang_flag_d;

    logic            mem_we;
    logic [PC_W-1:0] mem_rdata;

    pc_trace_mem #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (i_exp_addr),
        .i_wdata (i_exp_data),
        .i_raddr (idx_q),
        .o_rdata (mem_rdata)
    );

    // Loading is only allowed while no run has started since reset.
    assign mem_we = i_exp_we && (state_q == ST_IDLE);

    // NOTE: every signal assigned here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ret_d   = ret_q;
        hang_d  = hang_q;
        err_d   = err_q;
        cap_d   = cap_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_HANG: begin
                if (i_start) begin
                    idx_d   = '0;
                    ret_d   = '0;
                    hang_d  = '0;
                    err_d   = '0;
                    cap_d   = '0;
                    len_d   = i_exp_len;
                    state_d = (i_exp_len == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (i_insn_vld) begin
                    if (i_pc != mem_rdata) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        // A zero count means no mismatch yet this run; once
                        // non-zero it never returns to zero, even saturated.
                        if (err_q == '0) begin
                            cap_d.idx = TRACE_IDX_W_MAX'(idx_q);
                            cap_d.pc  = TRACE_PC_W_MAX'(i_pc);
                        end
                    end
                    idx_d  = idx_q + IDX_W'(1);
                    ret_d  = ret_q + (IDX_W + 1)'(1);
                    hang_d = '0;
                    // Final retirement wins over any hang condition.
                    if (ret_d == len_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    hang_d = hang_q + HC_W'(1);
                    if (hang_d == HC_W'(HANG_LIMIT)) begin
                        state_d = ST_HANG;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Status flags are decoded from the next state so they can be
        // registered and appear together with the state they describe.
        busy_d      = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE) || (state_d == ST_HANG);
        pass_d      = (state_d == ST_DONE) && (err_d == '0);
        fail_d      = ((state_d == ST_DONE) && (err_d != '0)) || (state_d == ST_HANG);
        hang_flag_d = (state_d == ST_HANG);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            ret_q       <= '0;
            hang_q      <= '0;
            err_q       <= '0;
            cap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            hang_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            ret_q       <= ret_d;
            hang_q      <= hang_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            hang_flag_q <= hang_flag_d;
        end
    end

    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_pass          = pass_q;
    assign o_fail          = fail_q;
    assign o_hang          = hang_flag_q;
    assign o_err_cnt       = err_q;
    assign o_ret_cnt       = ret_q;
    assign o_first_err_idx = cap_q.idx[IDX_W-1:0];
    assign o_first_err_pc  = cap_q.pc[PC_W-1:0];

endmodule

// File: tb/tb_pc_trace_checker.sv
// Self-checking bench for pc_trace_checker (DEPTH=16, HANG_LIMIT=8, ERR_W=2).
// A run-level reference model tracks the checker outcome from plain counts.
module tb_pc_trace_checker;

    localparam int PC_W  = 32;
    localparam int DEPTH = 16;
    localparam int HLIM  = 8;
    localparam int ERR_W = 2;
    localparam int IDX_W = 4;
    localparam int EMAX  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             exp_we;
    logic [IDX_W-1:0] exp_addr;
    logic [PC_W-1:0]  exp_data;
    logic             start;
    logic [IDX_W:0]   exp_len;
    logic [PC_W-1:0]  pc_in;
    logic             insn_vld;
    logic             busy, done, pass, fail, hang;
    logic [ERR_W-1:0] err_cnt;
    logic [IDX_W:0]   ret_cnt;
    logic [IDX_W-1:0] first_idx;
    logic [PC_W-1:0]  first_pc;

    pc_trace_checker #(
        .PC_W       (PC_W),
        .DEPTH      (DEPTH),
        .HANG_LIMIT (HLIM),
        .ERR_W      (ERR_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_exp_we        (exp_we),
        .i_exp_addr      (exp_addr),
        .i_exp_data      (exp_data),
        .i_start         (start),
        .i_exp_len       (exp_len),
        .i_pc            (pc_in),
        .i_insn_vld      (insn_vld),
        .o_busy          (busy),
        .o_done          (done),
        .o_pass          (pass),
        .o_fail          (fail),
        .o_hang          (hang),
        .o_err_cnt       (err_cnt),
        .o_ret_cnt       (ret_cnt),
        .o_first_err_idx (first_idx),
        .o_first_err_pc  (first_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_state: 0 idle, 1 running, 2 finished, 3 hung
    logic [PC_W-1:0] gold [DEPTH];
    int              m_state, m_len, m_ret, m_mis, m_idle, m_fidx;
    logic [PC_W-1:0] m_fpc;

    task automatic m_reset();
        m_state = 0; m_len = 0; m_ret = 0; m_mis = 0; m_idle = 0;
        m_fidx = 0; m_fpc = '0;
    endtask

    task automatic m_update(input bit vld, input logic [PC_W-1:0] pc, input bit st, input int len);
        if (m_state != 1) begin
            if (st) begin
                m_ret = 0; m_mis = 0; m_idle = 0; m_fidx = 0; m_fpc = '0;
                m_len = len;
                m_state = (len == 0) ? 2 : 1;
            end
        end else if (vld) begin
            if (pc != gold[m_ret]) begin
                if (m_mis == 0) begin
                    m_fidx = m_ret;
                    m_fpc  = pc;
                end
                m_mis++;
            end
            m_ret++;
            m_idle = 0;
            if (m_ret == m_len) m_state = 2;
        end else begin
            m_idle++;
            if (m_idle == HLIM) m_state = 3;
        end
    endtask

    task automatic check_all(input string w);
        check({w, ".busy"}, 64'(busy), 64'(m_state == 1));
        check({w, ".done"}, 64'(done), 64'(m_state >= 2));
        check({w, ".pass"}, 64'(pass), 64'(m_state == 2 && m_mis == 0));
        check({w, ".fail"}, 64'(fail), 64'((m_state == 2 && m_mis > 0) || m_state == 3));
        check({w, ".hang"}, 64'(hang), 64'(m_state == 3));
        check({w, ".err"},  64'(err_cnt), 64'((m_mis > EMAX) ? EMAX : m_mis));
        check({w, ".ret"},  64'(ret_cnt), 64'(m_ret));
        check({w, ".fidx"}, 64'(first_idx), 64'(m_fidx));
        check({w, ".fpc"},  64'(first_pc), 64'(m_fpc));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit vld, input logic [PC_W-1:0] pc, input bit st, input int len);
        insn_vld = vld;
        pc_in    = pc;
        start    = st;
        exp_len  = (IDX_W + 1)'(len);
        @(posedge clk);
        #1;
        insn_vld = 1'b0;
        start    = 1'b0;
        exp_we   = 1'b0;
        m_update(vld, pc, st, len);
        check_all("step");
    endtask

    task automatic write_mem(input int addr, input logic [PC_W-1:0] data);
        exp_we   = 1'b1;
        exp_addr = IDX_W'(addr);
        exp_data = data;
        if (m_state == 0) gold[addr] = data;
        step(1'b0, $urandom, 1'b0, 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_pcs(input int len, input logic [PC_W-1:0] pcs [$]);
        step(1'b0, '0, 1'b1, len);
        foreach (pcs[i]) step(1'b1, pcs[i], 1'b0, 0);
    endtask

    initial begin
        logic [PC_W-1:0] q [$];
        rst_n = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        start = 1'b0; exp_len = '0; pc_in = '0; insn_vld = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) write_mem(i, 32'(i * 4));

        // Clean run
        q = '{32'h0, 32'h4, 32'h8, 32'hC};
        run_pcs(4, q);
        check("clean.pass", 64'(pass), 64'd1);
        check("clean.ret",  64'(ret_cnt), 64'd4);
        check("clean.err",  64'(err_cnt), 64'd0);

        // Mismatch capture
        q = '{32'h0, 32'h4, 32'h10, 32'h14};
        run_pcs(4, q);
        check("mis.fail", 64'(fail), 64'd1);
        check("mis.err",  64'(err_cnt), 64'd2);
        check("mis.fidx", 64'(first_idx), 64'd2);
        check("mis.fpc",  64'(first_pc), 64'h10);

        // Hang: one retirement then idle
        q = '{32'h0};
        run_pcs(4, q);
        for (int i = 0; i < HLIM - 1; i++) step(1'b0, '0, 1'b0, 0);
        check("hang.early", 64'(hang), 64'd0);
        step(1'b0, '0, 1'b0, 0);
        check("hang.flag", 64'(hang), 64'd1);
        check("hang.fail", 64'(fail), 64'd1);
        check("hang.ret",  64'(ret_cnt), 64'd1);

        // Idle streak of HANG_LIMIT-1 then a retirement: no hang
        q = '{32'h0};
        run_pcs(3, q);
        for (int i = 0; i < HLIM - 1; i++) step(1'b0, '0, 1'b0, 0);
        step(1'b1, 32'h4, 1'b0, 0);
        check("nohang.busy", 64'(busy), 64'd1);
        step(1'b1, 32'h8, 1'b0, 0);

        // Saturation
        q = '{32'hF00, 32'hF04, 32'hF08, 32'hF0C, 32'hF10, 32'hF14};
        run_pcs(6, q);
        check("sat.err",  64'(err_cnt), 64'd3);
        check("sat.fail", 64'(fail), 64'd1);

        // Gated inputs: write and start during RUN are ignored
        step(1'b0, '0, 1'b1, 4);
        step(1'b1, 32'h0, 1'b0, 0);
        write_mem(0, 32'hDEAD);
        step(1'b1, 32'h4, 1'b1, 0);
        step(1'b1, 32'h8, 1'b0, 0);
        step(1'b1, 32'hC, 1'b0, 0);
        check("gate.pass", 64'(pass), 64'd1);
        write_mem(1, 32'hBEEF);
        q = '{32'h0, 32'h4, 32'h8, 32'hC};
        run_pcs(4, q);
        check("gate.mem", 64'(pass), 64'd1);

        // Zero-length run
        step(1'b0, '0, 1'b1, 0);
        check("len0.pass", 64'(pass), 64'd1);
        check("len0.done", 64'(done), 64'd1);

        // Asynchronous reset mid-run, then restart on the retained trace
        q = '{32'h0, 32'h4};
        run_pcs(4, q);
        check("arst.busy", 64'(busy), 64'd1);
        do_reset();
        q = '{32'h0, 32'h4, 32'h8, 32'hC};
        run_pcs(4, q);
        check("arst.pass", 64'(pass), 64'd1);

        // Randomized runs against the model
        for (int g = 0; g < 4; g++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) write_mem(i, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            for (int r = 0; r < 8; r++) begin
                int len;
                int guard;
                len = $urandom_range(1, DEPTH);
                step(1'b0, $urandom, 1'b1, len);
                guard = 0;
                while (m_state == 1 && guard < 400) begin
                    int gap;
                    gap = ($urandom_range(0, 11) == 0) ? $urandom_range(HLIM - 2, HLIM + 2)
                                                      : $urandom_range(0, 2);
                    for (int k = 0; k < gap && m_state == 1; k++) begin
                        step(1'b0, $urandom, $urandom_range(0, 7) == 0, 0);
                        guard++;
                    end
                    if (m_state == 1) begin
                        logic [PC_W-1:0] p;
                        p = ($urandom_range(0, 3) == 0) ? $urandom : gold[m_ret];
                        step(1'b1, p, 1'b0, 0);
                        guard++;
                    end
                end
                check("rand.bounded", 64'(m_state != 1), 64'd1);
                // idle cycles after a finished run must not disturb outputs
                step($urandom_range(0, 1) == 1, $urandom, 1'b0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_trace_checker.md
# pc_trace_checker

Parametrised, synthesizable commit-trace checker for the non-forwarding RV32I core bench. It generalises the single-run scoreboard to a configurable depth and width, with hang detection and error capture. It sits beside the core and watches `o_pc_debug`/`o_insn_vld`. Each retired PC is compared against a preloaded golden trace, and the checker reports pass/fail, mismatch count, first-error location and hang, either to the bench or to FPGA LEDs.

## Interface

Parameters:
- `PC_W`, 32: PC width.
- `DEPTH`, 1024: golden trace entries; `IDX_W = $clog2(DEPTH)`.
- `HANG_LIMIT`, 256: consecutive cycles without `i_insn_vld` in RUN that declare a hang (≥2).
- `ERR_W`, 8: error counter width; saturates.

Ports:
- `i_clk` in, 1: clock.
- `i_rst_n` in, 1: reset, asynchronous, active-low.
- `i_exp_we` in, 1: golden trace write strobe; honoured only in IDLE.
- `i_exp_addr` in, IDX_W: golden trace write index.
- `i_exp_data` in, PC_W: expected PC.
- `i_start` in, 1: begin a check run.
- `i_exp_len` in, IDX_W+1: number of instructions to check (0..DEPTH); sampled with `i_start`.
- `i_pc` in, PC_W: core retired PC (`o_pc_debug`).
- `i_insn_vld` in, 1: core retire valid (`o_insn_vld`).
- `o_busy` out, 1: in RUN.
- `o_done` out, 1: in DONE or HANG.
- `o_pass` out, 1: DONE with zero errors.
- `o_fail` out, 1: DONE with errors, or HANG.
- `o_hang` out, 1: in HANG.
- `o_err_cnt` out, ERR_W: saturating mismatch count.
- `o_ret_cnt` out, IDX_W+1: retirements checked.
- `o_first_err_idx` out, IDX_W: trace index of first mismatch.
- `o_first_err_pc` out, PC_W: observed PC at first mismatch.

## Operation

- FSM states: IDLE, RUN, DONE, HANG.
- IDLE:
  - `i_exp_we` writes `mem[i_exp_addr] <= i_exp_data`.
  - `i_start` with `i_exp_len` > 0 → RUN, clearing all counters and captures.
  - `i_start` with `i_exp_len` == 0 → DONE, with pass.
- RUN, each cycle with `i_insn_vld`:
  - Compare `i_pc` against `mem[idx]`.
  - On mismatch, increment `o_err_cnt`, saturating at 2^ERR_W−1.
  - On the first mismatch of the run, capture idx and `i_pc` into the first-error outputs.
  - Increment idx and `o_ret_cnt`, and clear the hang counter.
  - When this retirement is index `len−1`, go to DONE.
- RUN, each cycle without `i_insn_vld`: increment the hang counter. When it reaches HANG_LIMIT → HANG.
- DONE/HANG: outputs hold. `i_start` restarts the run as from IDLE; trace memory is retained. `i_exp_we` is ignored.
- `i_start` in RUN is ignored. `i_insn_vld` in IDLE/DONE/HANG is ignored.
- Memory writes outside IDLE are dropped silently.
- Trace memory read is combinational on idx. All outputs are registered.

## Timing

- Reset values: state IDLE; every output 0; idx, hang counter and captures 0. Memory contents are not reset.
- Reset asserted mid-RUN aborts immediately and returns all outputs to 0.
- Compare latency: `o_err_cnt`, `o_ret_cnt` and the first-error outputs update on the clock edge that samples `i_insn_vld`. They are visible one cycle after the retirement is presented.
- The final retirement and the DONE transition happen on the same edge. `o_done`/`o_pass`/`o_fail` are valid the following cycle, and `o_busy` drops on that cycle.
- Hang: the HANG transition occurs on the edge where the idle count reaches HANG_LIMIT, i.e. the HANG_LIMIT-th consecutive idle cycle. A `i_insn_vld` on that same cycle takes priority: the retirement counts and no hang is declared.
- The final retirement of a run takes priority over hang.
- `o_pass` and `o_fail` are never both 1.

## Structure

- Package `pc_trace_chk_pkg` holds:
  - the state enum `trace_chk_state_e` (IDLE, RUN, DONE, HANG);
  - a `localparam` default for HANG_LIMIT;
  - a `trace_err_t` struct {idx, pc} for the first-error capture.
- Sub-module `pc_trace_mem`: a DEPTH×PC_W single-write, asynchronous-read array with no reset, inferable as distributed RAM on FPGA.
- The top holds the FSM, counters and capture logic.

## Test plan

- Clean run: load 4 entries (0x0, 0x4, 0x8, 0xC); start with len=4; present matching PCs on 4 consecutive cycles → `o_done`=1, `o_pass`=1, `o_err_cnt`=0, `o_ret_cnt`=4.
- Mismatch capture: same trace, core retires 0x0, 0x4, 0x10, 0x14 → `o_fail`=1, `o_err_cnt`=2, `o_first_err_idx`=2, `o_first_err_pc`=0x10.
- Hang with HANG_LIMIT=8: retire 1 instruction, then hold `i_insn_vld` low → `o_hang`=1 and `o_fail`=1 exactly 8 idle cycles later, `o_ret_cnt`=1.
- Saturation with ERR_W=2: 6 mismatching retirements with len=6 → `o_err_cnt`=3, `o_fail`=1.
- Gated inputs: `i_exp_we` during RUN leaves memory unchanged (verified by a subsequent pass). `i_start` during RUN is ignored. `i_start` with len=0 → pass on the next cycle.
- Async reset: deassert `i_rst_n` mid-RUN, between clock edges → all outputs 0 immediately. Restart with the retained trace → pass.
